// File: rtl/conv_pkg.sv
// conv_engine shared types and defaults.
// State encoding, served-command tags and accumulator width helper.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLOAD,
    SLOAD,
    MAC,
    SHIFT,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    CMD_COEFF,
    CMD_SAMPLE,
    CMD_CONV,
    CMD_SHIFT
  } cmd_t;

  localparam int TAPS_DEF    = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int NUM_OUT_DEF = 3;

  function automatic int acc_w(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/conv_engine_if.sv
// Command/status/stream bundle between the convolution controller
// (master) and conv_engine (slave).
interface conv_engine_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_w(DATA_W_DEF, TAPS_DEF)
);

  logic                     load_coeff;
  logic                     load_sample;
  logic                     start_conv;
  logic                     shift;
  logic signed [DATA_W-1:0] data_in;
  logic                     data_valid;
  logic                     coeff_loaded;
  logic                     sample_loaded;
  logic                     conv_complete;
  logic                     sample_complete;
  logic signed [ACC_W-1:0]  result;

  modport master (
    output load_coeff, load_sample, start_conv, shift,
    output data_in, data_valid,
    input  coeff_loaded, sample_loaded,
    input  conv_complete, sample_complete,
    input  result
  );

  modport slave (
    input  load_coeff, load_sample, start_conv, shift,
    input  data_in, data_valid,
    output coeff_loaded, sample_loaded,
    output conv_complete, sample_complete,
    output result
  );

endinterface

// File: rtl/conv_mac.sv
// Serial signed MAC with a held result register.
// CONV_ENGINE_SAT_EN clamps result to the 2*DATA_W signed range.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_w(DATA_W_DEF, TAPS_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     step,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] coeff,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  result
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] clamped;

  assign prod = coeff * sample;
  assign sum  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef CONV_ENGINE_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  // clamp the final sum into the product-width range
  always_comb begin
    clamped = sum;
    if (sum > SMAX)
      clamped = SMAX;
    else if (sum < SMIN)
      clamped = SMIN;
  end
`else
  assign clamped = sum;
`endif

  // running accumulator, cleared on MAC entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (step)
      acc <= sum;
  end

  // result captures the sum including the final tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      result <= '0;
    else if (last)
      result <= clamped;
  end

endmodule

// File: rtl/conv_engine.sv
// Convolution datapath responder: coefficient/window load, serial MAC.
// Optional result clamping via CONV_ENGINE_SAT_EN (see conv_mac).
module conv_engine
  import conv_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_OUT = NUM_OUT_DEF
) (
  input logic         clk,
  input logic         rst,
  conv_engine_if.slave bus
);

  localparam int ACC_W = acc_w(DATA_W, TAPS);
  localparam int IW    = $clog2(TAPS);
  localparam int OW    = $clog2(NUM_OUT + 1);

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;

  logic [IW-1:0] cidx, scnt, tidx;
  logic [OW-1:0] out_cnt;

  logic signed [DATA_W-1:0] coeff [TAPS];
  logic signed [DATA_W-1:0] win   [TAPS];
  logic signed [ACC_W-1:0]  result;

  logic cmd_act;
  logic c_we, c_clr;
  logic w_shift, s_inc, s_clr;
  logic t_step, t_clr;
  logic mac_clr, mac_step, mac_last;
  logic o_inc, o_clr;
  logic cl_d, sl_d, cc_d, sc_d;
  logic cl_q, sl_q, cc_q, sc_q;

  // level of the command most recently served, for ACK
  always_comb begin
    cmd_act = 1'b0;
    unique case (cmd_q)
      CMD_COEFF:  cmd_act = bus.load_coeff;
      CMD_SAMPLE: cmd_act = bus.load_sample;
      CMD_CONV:   cmd_act = bus.start_conv;
      CMD_SHIFT:  cmd_act = bus.shift;
    endcase
  end

  // next state and datapath controls
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    c_we     = 1'b0;
    c_clr    = 1'b0;
    w_shift  = 1'b0;
    s_inc    = 1'b0;
    s_clr    = 1'b0;
    t_step   = 1'b0;
    t_clr    = 1'b0;
    mac_clr  = 1'b0;
    mac_step = 1'b0;
    mac_last = 1'b0;
    o_inc    = 1'b0;
    o_clr    = 1'b0;
    cl_d     = 1'b0;
    sl_d     = 1'b0;
    cc_d     = 1'b0;
    sc_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_coeff) begin
          state_d = CLOAD;
          cmd_d   = CMD_COEFF;
        end else if (bus.load_sample) begin
          state_d = SLOAD;
          cmd_d   = CMD_SAMPLE;
          s_clr   = 1'b1;
          o_clr   = 1'b1;
        end else if (bus.start_conv) begin
          state_d = MAC;
          cmd_d   = CMD_CONV;
          mac_clr = 1'b1;
          t_clr   = 1'b1;
        end else if (bus.shift) begin
          state_d = SHIFT;
          cmd_d   = CMD_SHIFT;
        end
      end
      CLOAD: begin
        if (!bus.load_coeff) begin
          state_d = IDLE;
          c_clr   = 1'b1;
        end else if (bus.data_valid) begin
          c_we = 1'b1;
          if (cidx == IW'(TAPS - 1)) begin
            cl_d    = 1'b1;
            c_clr   = 1'b1;
            state_d = ACK;
          end
        end
      end
      SLOAD: begin
        if (!bus.load_sample) begin
          state_d = IDLE;
          s_clr   = 1'b1;
        end else if (bus.data_valid) begin
          w_shift = 1'b1;
          s_inc   = 1'b1;
          if (scnt == IW'(TAPS - 1)) begin
            sl_d    = 1'b1;
            s_clr   = 1'b1;
            state_d = ACK;
          end
        end
      end
      MAC: begin
        if (!bus.start_conv) begin
          state_d = IDLE;
          t_clr   = 1'b1;
        end else begin
          mac_step = 1'b1;
          t_step   = 1'b1;
          if (tidx == IW'(TAPS - 1)) begin
            mac_last = 1'b1;
            cc_d     = 1'b1;
            o_inc    = (out_cnt != OW'(NUM_OUT));
            t_clr    = 1'b1;
            state_d  = ACK;
          end
        end
      end
      SHIFT: begin
        if (!bus.shift) begin
          state_d = IDLE;
        end else if (out_cnt == OW'(NUM_OUT)) begin
          sc_d    = 1'b1;
          o_clr   = 1'b1;
          state_d = ACK;
        end else if (bus.data_valid) begin
          w_shift = 1'b1;
          sl_d    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!cmd_act)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and served-command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_COEFF;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // load, tap and output counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cidx    <= '0;
      scnt    <= '0;
      tidx    <= '0;
      out_cnt <= '0;
    end else begin
      if (c_clr)
        cidx <= '0;
      else if (c_we)
        cidx <= cidx + 1'b1;
      if (s_clr)
        scnt <= '0;
      else if (s_inc)
        scnt <= scnt + 1'b1;
      if (t_clr)
        tidx <= '0;
      else if (t_step)
        tidx <= tidx + 1'b1;
      if (o_clr)
        out_cnt <= '0;
      else if (o_inc)
        out_cnt <= out_cnt + 1'b1;
    end
  end

  // coefficient bank and sample window; win[0] is newest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coeff[i] <= '0;
        win[i]   <= '0;
      end
    end else begin
      if (c_we)
        coeff[cidx] <= bus.data_in;
      if (w_shift) begin
        win[0] <= bus.data_in;
        for (int i = 1; i < TAPS; i++)
          win[i] <= win[i-1];
      end
    end
  end

  // one-cycle registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cl_q <= 1'b0;
      sl_q <= 1'b0;
      cc_q <= 1'b0;
      sc_q <= 1'b0;
    end else begin
      cl_q <= cl_d;
      sl_q <= sl_d;
      cc_q <= cc_d;
      sc_q <= sc_d;
    end
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .step   (mac_step),
    .last   (mac_last),
    .coeff  (coeff[tidx]),
    .sample (win[tidx]),
    .result (result)
  );

  assign bus.coeff_loaded    = cl_q;
  assign bus.sample_loaded   = sl_q;
  assign bus.conv_complete   = cc_q;
  assign bus.sample_complete = sc_q;
  assign bus.result          = result;

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine (TAPS=4, DATA_W=8, NUM_OUT=3).
// Expected results are queued at start_conv and popped on conv_complete.
module tb_conv_engine;
  import conv_pkg::*;

`ifdef CONV_ENGINE_SAT_EN
  localparam longint SAT_EXP = 32767;
`else
  localparam longint SAT_EXP = 65536;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_engine_if #(.DATA_W(8), .ACC_W(18)) bus ();

  conv_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  int     n_cl   = 0;
  int     n_sl   = 0;
  int     n_sc   = 0;
  longint sb[$];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bus.data_in    = 8'(v);
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic load4(input bit is_coeff, input int v0, input int v1,
                       input int v2, input int v3);
    int v[4];
    v = '{v0, v1, v2, v3};
    if (is_coeff)
      bus.load_coeff = 1'b1;
    else
      bus.load_sample = 1'b1;
    tick();
    for (int i = 0; i < 4; i++)
      send(v[i]);
    if (is_coeff)
      check("coeff_loaded", bus.coeff_loaded, 1);
    else
      check("sample_loaded", bus.sample_loaded, 1);
    bus.load_coeff  = 1'b0;
    bus.load_sample = 1'b0;
    tick();
    tick();
  endtask

  task automatic conv(input longint exp);
    int n;
    sb.push_back(exp);
    bus.start_conv = 1'b1;
    n = 0;
    while (!bus.conv_complete && n < 20) begin
      tick();
      n++;
    end
    check("conv_latency", n, 5);
    bus.start_conv = 1'b0;
    tick();
    tick();
  endtask

  task automatic shift_in(input int v);
    bus.shift = 1'b1;
    tick();
    send(v);
    check("shift_loaded", bus.sample_loaded, 1);
    bus.shift = 1'b0;
    tick();
    tick();
  endtask

  // monitor: pulse counts and scoreboard compare on conv_complete
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.coeff_loaded)    n_cl++;
      if (bus.sample_loaded)   n_sl++;
      if (bus.sample_complete) n_sc++;
      if (bus.conv_complete) begin
        if (sb.size() == 0)
          check("sb_empty", 1, 0);
        else
          check("result", longint'($signed(bus.result)), sb.pop_front());
      end
    end
  end

  initial begin
    int sl0;
    bus.load_coeff  = 1'b0;
    bus.load_sample = 1'b0;
    bus.start_conv  = 1'b0;
    bus.shift       = 1'b0;
    bus.data_in     = '0;
    bus.data_valid  = 1'b0;

    tick();
    tick();
    check("rst_cl", bus.coeff_loaded, 0);
    check("rst_sl", bus.sample_loaded, 0);
    check("rst_cc", bus.conv_complete, 0);
    check("rst_sc", bus.sample_complete, 0);
    check("rst_result", longint'($signed(bus.result)), 0);
    rst = 1'b0;
    tick();

    bus.load_coeff = 1'b1;
    tick();
    send(1);
    send(2);
    tick();
    send(3);
    send(4);
    check("cl_pulse", bus.coeff_loaded, 1);
    tick();
    check("cl_width", bus.coeff_loaded, 0);
    tick();
    tick();
    check("ack_hold", dut.state_q, ACK);
    check("cl_count", n_cl, 1);
    bus.load_coeff = 1'b0;
    tick();
    tick();

    load4(1'b0, 10, 20, 30, 40);
    conv(200);
    shift_in(50);
    conv(300);
    shift_in(60);
    conv(400);

    sl0 = n_sl;
    bus.shift      = 1'b1;
    bus.data_in    = 8'd99;
    bus.data_valid = 1'b1;
    tick();
    tick();
    check("sc_pulse", bus.sample_complete, 1);
    check("sc_no_sl", bus.sample_loaded, 0);
    tick();
    check("sc_width", bus.sample_complete, 0);
    bus.shift      = 1'b0;
    bus.data_valid = 1'b0;
    tick();
    tick();
    check("sc_count", n_sc, 1);
    check("sl_unchanged", n_sl, sl0);
    conv(400);

    load4(1'b1, -128, -128, -128, -128);
    load4(1'b0, -128, -128, -128, -128);
    conv(SAT_EXP);

    bus.start_conv = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_result", longint'($signed(bus.result)), 0);
    check("arst_cc", bus.conv_complete, 0);
    check("arst_cl", bus.coeff_loaded, 0);
    check("arst_sl", bus.sample_loaded, 0);
    check("arst_sc", bus.sample_complete, 0);
    bus.start_conv = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    conv(0);

    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_engine.md
# conv_engine

Datapath responder for the convolution controller. It receives that controller's level-held command strobes (`load_coeff`, `load_sample`, `start_conv`, `shift`) and returns its status pulses (`coeff_loaded`, `sample_loaded`, `conv_complete`, `sample_complete`). Internally it loads a coefficient bank and a sample window from a valid-qualified input stream, runs a serial multiply-accumulate, and presents each filter output.

## Interface
- `TAPS`, 4: number of coefficients and the sample window depth (≥2).
- `DATA_W`, 8: signed coefficient and sample width.
- `NUM_OUT`, 3: convolution results per run before `sample_complete` is asserted.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load_coeff`  in  1  controller command: accept coefficients.
- `load_sample`  in  1  controller command: fill the sample window.
- `start_conv`  in  1  controller command: run the MAC.
- `shift`  in  1  controller command: advance the window, or finish the run.
- `data_in`  in  DATA_W  signed stream data.
- `data_valid`  in  1  qualifies `data_in`.
- `coeff_loaded`  out  1  one-cycle pulse: coefficient bank is full.
- `sample_loaded`  out  1  one-cycle pulse: window filled or shifted.
- `conv_complete`  out  1  one-cycle pulse: `result` has been updated.
- `sample_complete`  out  1  one-cycle pulse: `NUM_OUT` results have been produced.
- `result`  out  ACC_W  signed result, where ACC_W = 2*DATA_W + $clog2(TAPS). Held until the next `conv_complete`.

## Operation
- States: IDLE, CLOAD, SLOAD, MAC, SHIFT, ACK.
- In IDLE, command priority is `load_coeff` > `load_sample` > `start_conv` > `shift`.
- CLOAD:
  - Each `data_valid` beat writes `coeff[cidx]` and increments `cidx`.
  - After beat TAPS: pulse `coeff_loaded`, clear `cidx`, go to ACK.
  - Gaps in `data_valid` stall the load; they are not an error.
- SLOAD:
  - Each beat shifts `data_in` into `win[0]` (win[i] <= win[i-1]).
  - After TAPS beats: pulse `sample_loaded`, go to ACK.
  - Clears `out_cnt`.
- MAC:
  - On entry, clear the accumulator and tap index.
  - On each of TAPS cycles: acc += coeff[i]*win[i], with signed full-precision products.
  - When done: load `result`, pulse `conv_complete`, increment `out_cnt`, go to ACK.
  - The final value is result = Σ coeff[i]*win[i], where `win[0]` holds the newest sample.
- SHIFT:
  - If `out_cnt` == NUM_OUT: pulse `sample_complete` in the next cycle, clear `out_cnt`, go to ACK. No data is consumed.
  - Otherwise: wait for a beat, shift it in, pulse `sample_loaded`, go to ACK.
  - `sample_loaded` and `sample_complete` are never asserted together.
- ACK:
  - Stay here while the command that was just served is still high. This prevents a restart while the controller is leaving its state.
  - Return to IDLE when that command is low.
- If the active command deasserts before completion in CLOAD, SLOAD, MAC or SHIFT: abandon the operation, clear the in-flight index, return to IDLE, and emit no pulse. Registers already written keep their values.
- `data_valid` outside CLOAD, SLOAD or SHIFT is ignored.

## Timing
- Reset values:
  - All four status outputs are 0 and `result` is 0.
  - `coeff`, `win`, `acc`, `cidx`, `out_cnt` and the tap index are 0.
  - State is IDLE.
- Reset is asynchronous: outputs clear immediately on `rst` assertion, including mid-MAC.
- All outputs are registered, and every status pulse is exactly one cycle wide.
- Load latency: `coeff_loaded` / `sample_loaded` rise in the cycle after the edge that samples the final beat.
- MAC latency: `conv_complete` rises TAPS+1 cycles after the first cycle in which IDLE sees `start_conv` high. `result` is valid in that same cycle.
- Shift latency: `sample_loaded` rises in the cycle after the accepted beat. `sample_complete` rises 2 cycles after `shift` is first seen.

## Configuration
- `CONV_ENGINE_SAT_EN` defined:
  - `result` is clamped to the signed 2*DATA_W-bit range [-2^(2*DATA_W-1), 2^(2*DATA_W-1)-1], then sign-extended to ACC_W.
  - The clamp is applied at the `result` register.
- `CONV_ENGINE_SAT_EN` undefined: `result` is the full-precision ACC_W sum, with no clamping.

## Structure
- Package `conv_pkg` holds:
  - the engine state enum;
  - default `TAPS`, `DATA_W` and `NUM_OUT` constants;
  - an ACC_W helper function.
- Sub-module `conv_mac` holds the signed multiplier, the accumulator register, and the optional saturation stage.

## Test plan
All scenarios use TAPS=4, DATA_W=8, NUM_OUT=3.
- Coefficient load: hold `load_coeff`; send 1,2,3,4 with one idle gap → a single `coeff_loaded` pulse one cycle after beat 4; the state then sits in ACK until `load_coeff` drops.
- Initial window and convolution: `load_sample` with 10,20,30,40, then `start_conv` → `conv_complete` 5 cycles later; `result` = 200.
- Window shift: `shift` with 50 → `sample_loaded`; then `start_conv` → `result` = 300. Repeat with 60 → `result` = 400.
- End of run: after the 3rd result, `shift` → `sample_complete` pulse, no `sample_loaded`, and a pending `data_valid` beat is left unconsumed.
- Saturation: all coefficients and samples = -128 → `result` = 65536 without the macro, 32767 with it.
- Reset: assert `rst` during MAC cycle 2 → all outputs 0 immediately; after release, `start_conv` produces a fresh result from zeroed registers (`result` = 0).
